// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR pseudo-random generator.
// It provides the FSM encoding, the default tap masks and a single Fibonacci step.
package lfsr_pkg;

  typedef enum logic {
    ST_WARMUP,
    ST_RUN
  } fsm_e;

  // The widest LFSR the generic step helper supports.
  localparam int unsigned LFSR_MAX_W = 64;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hD008;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // One Fibonacci step on the low `width` bits: shift left, XOR of tapped bits enters at bit 0.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps,
    input int unsigned           width
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic                  fb;
    mask = (width >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1));
    fb   = ^(state & taps & mask);
    return ((state << 1) | LFSR_MAX_W'(fb)) & mask;
  endfunction

endpackage

// File: rtl/lfsr_step_n.sv
// Combinational unroll of STEPS chained LFSR steps.
// Each stage feeds the next, so the output is the state STEPS shifts ahead.
module lfsr_step_n
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W32),
  parameter int unsigned      STEPS = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] chain [STEPS+1];

  assign chain[0] = state_i;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    assign chain[i+1] = WIDTH'(lfsr_step(LFSR_MAX_W'(chain[i]), LFSR_MAX_W'(TAPS), WIDTH));
  end

  assign state_o = chain[STEPS];

endmodule

// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci LFSR with seed loading, warm-up, zero-state recovery
// and a valid/ready draw interface. WIDTH may range from 4 to 64.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH          = 32,
  parameter logic [WIDTH-1:0] TAPS           = WIDTH'(TAPS_W32),
  parameter logic [WIDTH-1:0] SEED           = WIDTH'(32'h0000_0001),
  parameter int unsigned      WARMUP_CYCLES  = 2,
  parameter int unsigned      STEPS_PER_DRAW = 1,
  parameter bit               FREE_RUN       = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             draw_ready,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_data,
  output logic             busy,
  output logic             lockup
);

  localparam int unsigned      CNT_W     = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] WARM_INIT = CNT_W'(WARMUP_CYCLES);
  localparam fsm_e             FSM_INIT  = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] step_one, step_draw;
  logic             fire;

  lfsr_step_n #(.WIDTH(WIDTH), .TAPS(TAPS), .STEPS(1)) u_step_warm (
    .state_i (state_q),
    .state_o (step_one)
  );

  lfsr_step_n #(.WIDTH(WIDTH), .TAPS(TAPS), .STEPS(STEPS_PER_DRAW)) u_step_draw (
    .state_i (state_q),
    .state_o (step_draw)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q      <= FSM_INIT;
      warm_cnt_q <= WARM_INIT;
      state_q    <= SEED;
      lockup_q   <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      warm_cnt_q <= warm_cnt_d;
      state_q    <= state_d;
      lockup_q   <= lockup_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    fsm_d      = fsm_q;
    warm_cnt_d = warm_cnt_q;
    state_d    = state_q;
    fire       = rnd_valid & draw_ready;

    if (seed_load) begin
      state_d    = (seed_in == '0) ? SEED : seed_in;
      warm_cnt_d = WARM_INIT;
      fsm_d      = FSM_INIT;
    end else if (state_q == '0) begin
      state_d = SEED;
    end else begin
      unique case (fsm_q)
        ST_WARMUP: begin
          state_d    = step_one;
          warm_cnt_d = warm_cnt_q - CNT_W'(1);
          if (warm_cnt_q == CNT_W'(1)) fsm_d = ST_RUN;
        end
        ST_RUN: begin
          if (fire || FREE_RUN) state_d = step_draw;
        end
        default: fsm_d = FSM_INIT;
      endcase
    end

    // Registered so the pulse lines up with the cycle that shows the all-zero state.
    lockup_d = (state_d == '0);
  end

  always_comb begin
    rnd_valid = (fsm_q == ST_RUN);
    busy      = (fsm_q == ST_WARMUP);
  end

  assign rnd_data = state_q;
  assign lockup   = lockup_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: three configurations driven by one directed
// sequence, expected draws queued from an independent step model and popped on output.
module tb_lfsr_prng;

  logic clk;
  logic reset_n;

  logic       seed_load_a, ready_a, valid_a, busy_a, lockup_a;
  logic [7:0] seed_in_a, data_a;
  logic       seed_load_b, ready_b, valid_b, busy_b, lockup_b;
  logic [7:0] seed_in_b, data_b;
  logic        seed_load_c, ready_c, valid_c, busy_c, lockup_c;
  logic [31:0] seed_in_c, data_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_a[$];
  logic [31:0] sb_b[$];
  logic [31:0] sb_bl[$];
  logic [31:0] sb_c[$];

  lfsr_prng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .WARMUP_CYCLES(2),
              .STEPS_PER_DRAW(1), .FREE_RUN(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load_a), .seed_in(seed_in_a),
    .draw_ready(ready_a), .rnd_valid(valid_a), .rnd_data(data_a), .busy(busy_a), .lockup(lockup_a));

  lfsr_prng #(.WIDTH(8), .TAPS(8'h02), .SEED(8'h01), .WARMUP_CYCLES(0),
              .STEPS_PER_DRAW(1), .FREE_RUN(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load_b), .seed_in(seed_in_b),
    .draw_ready(ready_b), .rnd_valid(valid_b), .rnd_data(data_b), .busy(busy_b), .lockup(lockup_b));

  lfsr_prng #(.WIDTH(32), .TAPS(32'h8020_0003), .SEED(32'h1), .WARMUP_CYCLES(2),
              .STEPS_PER_DRAW(4), .FREE_RUN(1'b0)) dut_c (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load_c), .seed_in(seed_in_c),
    .draw_ready(ready_c), .rnd_valid(valid_c), .rnd_data(data_c), .busy(busy_c), .lockup(lockup_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] m_step8(input logic [7:0] s, input logic [7:0] t);
    return {s[6:0], ^(s & t)};
  endfunction

  function automatic logic [31:0] m_step32(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  ea, eb, first_a;
    logic [31:0] ec;
    int          period;

    reset_n = 1'b0;
    seed_load_a = 1'b0; seed_in_a = '0; ready_a = 1'b0;
    seed_load_b = 1'b0; seed_in_b = '0; ready_b = 1'b0;
    seed_load_c = 1'b0; seed_in_c = '0; ready_c = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("a_rst_valid", 32'(valid_a), 32'd0);
    check("a_rst_busy", 32'(busy_a), 32'd1);
    check("a_rst_data", 32'(data_a), 32'h01);
    check("a_rst_lockup", 32'(lockup_a), 32'd0);
    check("b_rst_valid", 32'(valid_b), 32'd1);
    check("b_rst_busy", 32'(busy_b), 32'd0);
    check("b_rst_data", 32'(data_b), 32'h01);
    check("c_rst_busy", 32'(busy_c), 32'd1);
    reset_n = 1'b1;

    // Warm-up: two single steps from the seed before the first valid draw.
    ea = m_step8(8'h01, 8'hB8);
    @(negedge clk);
    check("a_warm_busy", 32'(busy_a), 32'd1);
    check("a_warm_valid", 32'(valid_a), 32'd0);
    check("a_warm_data", 32'(data_a), 32'(ea));
    ea = m_step8(ea, 8'hB8);
    @(negedge clk);
    check("a_first_valid", 32'(valid_a), 32'd1);
    check("a_first_busy", 32'(busy_a), 32'd0);
    check("a_first_data", 32'(data_a), 32'h04);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("a_hold_valid", 32'(valid_a), 32'd1);
      check("a_hold_data", 32'(data_a), 32'(ea));
    end

    // Back-to-back draws give a new value every cycle.
    ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ea = m_step8(ea, 8'hB8);
      sb_a.push_back(32'(ea));
      @(negedge clk);
      check("a_draw", 32'(data_a), sb_a.pop_front());
    end

    // Seed load while a draw is offered: load wins, no advance, warm-up restarts.
    seed_load_a = 1'b1; seed_in_a = 8'h08;
    @(negedge clk);
    seed_load_a = 1'b0;
    check("a_load_busy", 32'(busy_a), 32'd1);
    check("a_load_data", 32'(data_a), 32'h08);
    ea = m_step8(8'h08, 8'hB8);
    @(negedge clk);
    check("a_load_warm", 32'(data_a), 32'(ea));
    ea = m_step8(ea, 8'hB8);
    @(negedge clk);
    ready_a = 1'b0;
    check("a_load_valid", 32'(valid_a), 32'd1);
    check("a_load_first", 32'(data_a), 32'(ea));

    // Zero seed_in falls back to the SEED parameter.
    seed_load_a = 1'b1; seed_in_a = 8'h00;
    @(negedge clk);
    seed_load_a = 1'b0;
    check("a_zseed_data", 32'(data_a), 32'h01);
    check("a_zseed_busy", 32'(busy_a), 32'd1);
    repeat (2) @(negedge clk);
    check("a_zseed_valid", 32'(valid_a), 32'd1);
    check("a_zseed_first", 32'(data_a), 32'h04);

    // Full period from 8'h04 under continuous draws.
    ea = 8'h04;
    first_a = 8'h04;
    period = 0;
    ready_a = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ea = m_step8(ea, 8'hB8);
      sb_a.push_back(32'(ea));
      @(negedge clk);
      period++;
      check("a_period_draw", 32'(data_a), sb_a.pop_front());
      if (data_a === first_a) break;
    end
    ready_a = 1'b0;
    check("a_period_len", 32'(period), 32'd255);

    // Lockup: with taps lacking the MSB, 8'h40 reaches zero in two steps.
    check("b_idle_hold", 32'(data_b), 32'h01);
    seed_load_b = 1'b1; seed_in_b = 8'h40; ready_b = 1'b1;
    @(negedge clk);
    seed_load_b = 1'b0;
    eb = 8'h40;
    for (int i = 0; i < 5; i++) begin
      sb_b.push_back(32'(eb));
      sb_bl.push_back((eb == 8'h00) ? 32'd1 : 32'd0);
      check("b_valid", 32'(valid_b), 32'd1);
      check("b_data", 32'(data_b), sb_b.pop_front());
      check("b_lockup", 32'(lockup_b), sb_bl.pop_front());
      eb = (eb == 8'h00) ? 8'h01 : m_step8(eb, 8'h02);
      @(negedge clk);
    end
    ready_b = 1'b0;

    // 32-bit, four steps per draw, against the golden model.
    ec = m_step32(m_step32(32'h1));
    check("c_first_valid", 32'(valid_c), 32'd1);
    check("c_first_data", data_c, ec);
    ready_c = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 4; k++) ec = m_step32(ec);
      sb_c.push_back(ec);
      @(negedge clk);
      check("c_draw", data_c, sb_c.pop_front());
    end
    ready_c = 1'b0;
    check("c_no_lockup", 32'(lockup_c), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
